div_stall_unit: RTL and testbench
=================================

Name: div_stall_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage.
- It produces the Stall signal that freezes the upstream pipeline registers while a divide is in flight.
- It releases the stall in the cycle the result is valid, so the pipeline advances exactly once per divide.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a power of 2 and at least 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a divide op. Stays high while the pipeline is stalled.
- op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- rs1  in  WIDTH  dividend.
- rs2  in  WIDTH  divisor.
- flush  in  1  kill the in-flight op (branch mispredict or trap).
- stall  out  1  freeze IF/ID/EX pipeline registers.
- busy  out  1  unit is in BUSY state.
- done  out  1  result valid this cycle.
- result  out  WIDTH  quotient or remainder.

Behaviour:
- Reset (rst_n low, any time, async): state=IDLE, counter=0, internal registers=0, result=0, done=0, busy=0. stall is combinational and follows.
- stall = start & ~done & ~flush. Combinational, so the stall appears in the same cycle the divide enters EX.
- IDLE:
  - On start & ~flush: latch op, take |rs1| and |rs2| (signed ops only), record the signs, clear the remainder, set counter=WIDTH, go to BUSY.
  - Operands are sampled only in this cycle.
- BUSY: one restoring step per cycle.
  - rem = {rem[WIDTH-2:0], quo[WIDTH-1]}, then quo <<= 1.
  - If rem >= divisor: rem -= divisor, quo[0] = 1.
  - Decrement the counter. When it reaches 0, apply sign correction and go to DONE.
- DONE: done=1, stall=0 and result is held for exactly one cycle; the pipeline captures it. Next state is IDLE.
  - A back-to-back divide is accepted in the following IDLE cycle.
- Latency:
  - start is first seen at cycle 0, BUSY occupies cycles 1..WIDTH, DONE is cycle WIDTH+1.
  - stall is high for cycles 0..WIDTH, i.e. WIDTH+1 stalled cycles.
- Sign correction:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops are never corrected.
- Boundary results, mandatory in both macro configurations:
  - Divide by zero: quotient = all-ones; remainder = rs1 unchanged (signed and unsigned).
  - Signed overflow, DIV/REM of most-negative by -1: quotient = most-negative, remainder = 0.
- flush: overrides everything in any state. Next state is IDLE, done=0, result holds its previous value, and no result is delivered.
- If start drops while BUSY without flush: protocol violation. The unit finishes and pulses done; the bench asserts this never occurs.
- busy=1 only in BUSY. done and busy are never both high.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE. The unit goes IDLE->DONE directly with the fixed result, so stall is high for cycle 0 only.
- Undefined: special cases take the full WIDTH-iteration path, and dedicated override logic forces the spec values in DONE. Latency is uniform at WIDTH+2 cycles in EX.

Decomposition:
- Package div_pkg:
  - op_e enum (DIV, DIVU, REM, REMU).
  - state_e enum (IDLE, BUSY, DONE).
  - Localparams for op encodings and the helper functions is_signed(op) and is_rem(op).
- Sub-module div_step: combinational single iteration, (rem, quo, divisor) -> (rem_next, quo_next).
- div_stall_unit holds the FSM, counter, sign handling and special-case logic.

Test Plan:
- DIVU 100/7, start held: stall high 33 cycles (0..32), done at cycle 33, result=14. REMU same operands -> result=2.
- DIV -100/7 -> -14 (0xFFFFFFF2); REM -100/7 -> -2 (0xFFFFFFFE); DIV 100/-7 -> -14.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - With DIV_FAST_SPECIAL_EN: done at cycle 1, stall high only at cycle 0.
- flush asserted at BUSY cycle 10: stall drops in that cycle, FSM in IDLE next cycle, no done pulse, result unchanged.
- rst_n pulsed low mid-BUSY (asynchronously, between clock edges): all outputs 0 immediately. A fresh DIVU 9/3 after release -> 3 with full latency.
- Back-to-back DIVU 9/3 then REMU 10/4: results 3 then 2, each with full latency; exactly one done pulse each; no cycle lost between them beyond one IDLE cycle.

Source files
------------

// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------+
// | div_pkg : op/state encodings and op-decode helpers for div_stall_unit |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam logic [1:0] OP_DIV_ENC  = 2'b00;
  localparam logic [1:0] OP_DIVU_ENC = 2'b01;
  localparam logic [1:0] OP_REM_ENC  = 2'b10;
  localparam logic [1:0] OP_REMU_ENC = 2'b11;

  typedef enum logic [1:0] {
    OP_DIV  = OP_DIV_ENC,
    OP_DIVU = OP_DIVU_ENC,
    OP_REM  = OP_REM_ENC,
    OP_REMU = OP_REMU_ENC
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +----------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring division iteration    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;

  // Compare one bit wider so no partial remainder bit is ever discarded.
  assign w_shift  = {rem, quo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, divisor});
  assign w_sub    = w_shift[WIDTH-1:0] - divisor;
  assign rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_stall_unit.sv
// +----------------------------------------------------------------------+
// | div_stall_unit : iterative RV32M divider with EX-stage stall output   |
// | Option: DIV_FAST_SPECIAL_EN (div-by-zero / overflow skip iterations) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module div_stall_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_r, state_next;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] dividend_r, divisor_r, rem_r, quo_r, result_r;
  logic             neg_q_r, neg_r_r, div0_r, ovf_r;

  logic [WIDTH-1:0] w_abs1, w_abs2, w_rem_n, w_quo_n, w_final;
  logic             w_in_div0, w_in_ovf, w_fast_special, w_last;

  function automatic logic [WIDTH-1:0] special_val(input logic [1:0] o,
                                                   input logic [WIDTH-1:0] dvd,
                                                   input logic dz);
    if (dz) return is_rem(o) ? dvd : {WIDTH{1'b1}};
    return is_rem(o) ? {WIDTH{1'b0}} : MOST_NEG;
  endfunction

  assign w_abs1    = (is_signed(op) && rs1[WIDTH-1]) ? -rs1 : rs1;
  assign w_abs2    = (is_signed(op) && rs2[WIDTH-1]) ? -rs2 : rs2;
  assign w_in_div0 = (rs2 == '0);
  assign w_in_ovf  = is_signed(op) && (rs1 == MOST_NEG) && (rs2 == {WIDTH{1'b1}});
  assign w_last    = (cnt_r == CNT_W'(1));

`ifdef DIV_FAST_SPECIAL_EN
  assign w_fast_special = w_in_div0 | w_in_ovf;
`else
  assign w_fast_special = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (w_rem_n),
    .quo_next (w_quo_n)
  );

  // Final iteration result with sign correction; special cases override.
  always_comb begin
    w_final = is_rem(op_r) ? (neg_r_r ? -w_rem_n : w_rem_n)
                           : (neg_q_r ? -w_quo_n : w_quo_n);
    if (div0_r || ovf_r) w_final = special_val(op_r, dividend_r, div0_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:    if (start) state_next = w_fast_special ? DONE : BUSY;
      BUSY:    if (w_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    busy  = (state_r == BUSY);
    done  = (state_r == DONE) && !flush;
    stall = start && !done && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      op_r       <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      result_r   <= '0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div0_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (!flush) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r       <= op;
            dividend_r <= rs1;
            quo_r      <= w_abs1;
            divisor_r  <= w_abs2;
            rem_r      <= '0;
            cnt_r      <= CNT_W'(WIDTH);
            neg_q_r    <= is_signed(op) && (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
            neg_r_r    <= is_signed(op) && rs1[WIDTH-1];
            div0_r     <= w_in_div0;
            ovf_r      <= w_in_ovf;
            if (w_fast_special) result_r <= special_val(op, rs1, w_in_div0);
          end
        end
        BUSY: begin
          rem_r <= w_rem_n;
          quo_r <= w_quo_n;
          cnt_r <= cnt_r - CNT_W'(1);
          if (w_last) result_r <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;

endmodule

`default_nettype wire

// File: tb/tb_div_stall_unit.sv
// +----------------------------------------------------------------------+
// | tb_div_stall_unit : scoreboard bench for div_stall_unit               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_stall_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         stall, busy, done;
  logic [W-1:0] result;

  div_stall_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cnt = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Architectural RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    bit sgn;
    sgn = !o[0];
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    if (b == 32'h0) begin
      q = -1;
      r = sa;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = sa;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    bit special;
    special = (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
    if (special) return 1;
`else
    if (special) return W + 1;
`endif
    return W + 1;
  endfunction

  // Monitor: pops the scoreboard whenever the unit presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) stall_cnt++;
      if (busy) begin
        n_chk++;
        if (!start && !flush) begin
          n_fail++;
          $display("FAIL protocol: start dropped while busy (start=%0b flush=%0b)", start, flush);
        end
      end
      if (busy && done) begin
        n_chk++;
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", busy, done);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: done=1 with result %h, required no done", result);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk_int("latency", cyc - e.issue, e.lat);
          chk_int("stall_cycles", stall_cnt, e.lat);
        end
      end
    end
  end

  // Issue one divide at posedge+2, hold start until done, return at posedge+2.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    bit got;
    op = o;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    stall_cnt = 0;
    sbq.push_back('{res: model(o, a, b), issue: cyc, lat: exp_lat(o, a, b)});
    got = 0;
    for (int i = 0; i < 3 * W && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (scramble && i > 0) begin
        rs1 = $urandom;
        rs2 = $urandom;
        op = 2'($urandom);
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no done for op %0d %h/%h, required done", o, a, b);
      sbq.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] prev;
  logic [1:0]  ro;
  logic [31:0] ra, rb;
  int          mode, t;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 0);
    idle(1);
    run_op(2'b00, 32'd5, 32'd0, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(2);

    // Flush in BUSY cycle 10.
    prev = result;
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall}, 32'h0);
    chk("flush_done", {31'b0, done}, 32'h0);
    @(posedge clk);
    #2;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("flush_busy_next", {31'b0, busy}, 32'h0);
    chk("flush_result_hold", result, prev);
    idle(3);

    // Asynchronous reset in the middle of BUSY.
    op = 2'b01; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("areset_busy", {31'b0, busy}, 32'h0);
    chk("areset_done", {31'b0, done}, 32'h0);
    chk("areset_stall", {31'b0, stall}, 32'h0);
    chk("areset_result", result, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    run_op(2'b01, 32'd9, 32'd3, 0);

    // Back-to-back, start held throughout.
    run_op(2'b01, 32'd9, 32'd3, 0);
    run_op(2'b11, 32'd10, 32'd4, 0);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      mode = $urandom_range(0, 5);
      ra = $urandom;
      rb = $urandom;
      if (mode == 0) rb = 32'h0;
      else if (mode == 1) begin
        ro = {ro[1], 1'b0};
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (mode == 2) begin
        t = $urandom_range(0, 400);
        ra = 32'(t - 200);
        t = $urandom_range(1, 40);
        rb = ($urandom_range(0, 1) == 1) ? 32'(-t) : 32'(t);
      end else if (mode == 3) rb = rb >> $urandom_range(0, 31);
      run_op(ro, ra, rb, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    chk_int("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
